// File: rtl/tag_pio_pkg.sv
// Shared constants for the Nios PIO controller: register map, edge encodings
// and the pulse counter width helper.
package tag_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd1;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd3;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd4;
  localparam logic [2:0] ADDR_PULSE    = 3'd5;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  function automatic int unsigned pulse_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/tag_pio_edge_sync.sv
// Per-bit two-flop synchroniser with a delayed copy for edge detection.
module tag_pio_edge_sync
  import tag_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    edges = '0;
    if (EDGE_TYPE == EDGE_RISING)       edges = s2 & ~s3;
    else if (EDGE_TYPE == EDGE_FALLING) edges = ~s2 & s3;
    else                                edges = s2 ^ s3;
  end

  assign in_sync = s2;

endmodule

// File: rtl/tag_nios_system_pio_ctrl.sv
// Avalon-MM PIO slave: output register with set/clear and timed pulse,
// synchronised inputs with sticky edge capture and a maskable level irq.
module tag_nios_system_pio_ctrl
  import tag_pio_pkg::*;
#(
  parameter int unsigned     WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned     EDGE_TYPE    = EDGE_RISING,
  parameter int unsigned     PULSE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int unsigned CW = pulse_cnt_width(PULSE_CYCLES);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;
  logic [WIDTH-1:0] out_reg, irq_mask, edge_cap, pulse_mask;
  logic [WIDTH-1:0] in_sync, edges, cap_clr;
  logic [CW-1:0]    count;
  logic             busy, pulse_start;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign busy      = (count != '0);
  assign pulse_start = wr && (address == ADDR_PULSE) && !busy && (wd != '0);
  assign cap_clr   = (wr && address == ADDR_EDGE_CAP) ? wd : '0;

  tag_pio_edge_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .in_sync (in_sync),
    .edges   (edges)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg  <= RESET_VALUE;
      irq_mask <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:     out_reg  <= wd;
        ADDR_IRQ_MASK: irq_mask <= wd;
        ADDR_OUTSET:   out_reg  <= out_reg | wd;
        ADDR_OUTCLR:   out_reg  <= out_reg & ~wd;
        default: ;
      endcase
    end
  end

  // A new edge in the same cycle as a clear of that bit keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edges;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      pulse_mask <= '0;
    end else if (pulse_start) begin
      count      <= CW'(PULSE_CYCLES);
      pulse_mask <= wd;
    end else if (busy) begin
      count <= count - CW'(1);
      if (count == CW'(1)) pulse_mask <= '0;
    end
  end

  assign out_port = out_reg ^ (busy ? pulse_mask : '0);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(in_sync);
      ADDR_IRQ_MASK: readdata = 32'(irq_mask);
      ADDR_EDGE_CAP: readdata = 32'(edge_cap);
      ADDR_OUTSET,
      ADDR_OUTCLR:   readdata = 32'(out_reg);
      ADDR_PULSE:    readdata = (32'(pulse_mask) << 8) | 32'(busy);
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_tag_nios_system_pio_ctrl.sv
// Directed bench for the PIO controller: a rising-edge instance (a) and an
// any-edge instance (b) sharing clock, reset and bus, with separate selects.
`timescale 1ns/1ps
module tb_tag_nios_system_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        cs_a, cs_b, write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a, rd_b;
  logic [7:0]  in_a, in_b, out_a, out_b;
  logic        irq_a, irq_b;
  logic [31:0] rv;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  tag_nios_system_pio_ctrl #(
    .WIDTH(8), .RESET_VALUE(8'h01), .EDGE_TYPE(0), .PULSE_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .out_port(out_a), .irq(irq_a)
  );

  tag_nios_system_pio_ctrl #(
    .WIDTH(8), .RESET_VALUE(8'h01), .EDGE_TYPE(2), .PULSE_CYCLES(4)
  ) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .out_port(out_b), .irq(irq_b)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic to_b);
    @(negedge clk);
    address = a; writedata = d; write_n = 1'b0;
    if (to_b) cs_b = 1'b1; else cs_a = 1'b1;
    @(posedge clk); #1;
    write_n = 1'b1; cs_a = 1'b0; cs_b = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic to_b, output logic [31:0] d);
    address = a; write_n = 1'b1;
    if (to_b) cs_b = 1'b1; else cs_a = 1'b1;
    #1;
    d = to_b ? rd_b : rd_a;
    cs_a = 1'b0; cs_b = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [8];
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'h01, 32'h01, 32'h0, 32'h0, 32'h0};
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk); reset = 1'b0;
    step();
    total++; if (out_a !== 8'h01) begin bad++; $display("FAIL reset_out_a got=%h exp=01", out_a); end
    total++; if (out_b !== 8'h01) begin bad++; $display("FAIL reset_out_b got=%h exp=01", out_b); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_a); end
    for (int i = 0; i < 8; i++) begin
      bus_rd(3'(i), 1'b0, rv);
      total++;
      if (rv !== exp_rd[i]) begin bad++; $display("FAIL reset_read_%0d got=%h exp=%h", i, rv, exp_rd[i]); end
    end
  endtask

  task automatic test_setclr();
    bus_wr(3'd3, 32'hF0, 1'b0);
    total++; if (out_a !== 8'hF1) begin bad++; $display("FAIL outset got=%h exp=f1", out_a); end
    bus_wr(3'd4, 32'h30, 1'b0);
    total++; if (out_a !== 8'hC1) begin bad++; $display("FAIL outclr got=%h exp=c1", out_a); end
    bus_wr(3'd0, 32'h5A, 1'b0);
    total++; if (out_a !== 8'h5A) begin bad++; $display("FAIL data_wr got=%h exp=5a", out_a); end
    bus_rd(3'd4, 1'b0, rv);
    total++; if (rv !== 32'h5A) begin bad++; $display("FAIL outclr_read got=%h exp=5a", rv); end
    bus_wr(3'd0, 32'hFFFF_FF00, 1'b0);
    total++; if (out_a !== 8'h00) begin bad++; $display("FAIL data_upper_ignored got=%h exp=00", out_a); end
    bus_wr(3'd6, 32'hFF, 1'b0);
    bus_rd(3'd3, 1'b0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL unmapped_wr got=%h exp=0", rv); end
  endtask

  task automatic test_pulse();
    bus_wr(3'd5, 32'h04, 1'b0);
    total++; if (out_a !== 8'h04) begin bad++; $display("FAIL pulse_c1 got=%h exp=04", out_a); end
    bus_rd(3'd5, 1'b0, rv);
    total++; if (rv !== 32'h401) begin bad++; $display("FAIL pulse_busy_rd got=%h exp=401", rv); end
    bus_wr(3'd5, 32'h02, 1'b0);
    total++; if (out_a !== 8'h04) begin bad++; $display("FAIL pulse_c2_ignore got=%h exp=04", out_a); end
    bus_rd(3'd5, 1'b0, rv);
    total++; if (rv !== 32'h401) begin bad++; $display("FAIL pulse_ignore_rd got=%h exp=401", rv); end
    step();
    total++; if (out_a !== 8'h04) begin bad++; $display("FAIL pulse_c3 got=%h exp=04", out_a); end
    step();
    total++; if (out_a !== 8'h04) begin bad++; $display("FAIL pulse_c4 got=%h exp=04", out_a); end
    step();
    total++; if (out_a !== 8'h00) begin bad++; $display("FAIL pulse_end got=%h exp=00", out_a); end
    bus_rd(3'd5, 1'b0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL pulse_idle_rd got=%h exp=0", rv); end

    bus_wr(3'd5, 32'h04, 1'b0);
    bus_wr(3'd3, 32'h01, 1'b0);
    total++; if (out_a !== 8'h05) begin bad++; $display("FAIL pulse_under got=%h exp=05", out_a); end
    step(); step(); step();
    total++; if (out_a !== 8'h01) begin bad++; $display("FAIL pulse_under_end got=%h exp=01", out_a); end

    bus_wr(3'd0, 32'h00, 1'b0);
    bus_wr(3'd5, 32'h04, 1'b0);
    @(negedge clk); reset = 1'b1;
    step();
    total++; if (out_a !== 8'h01) begin bad++; $display("FAIL pulse_reset_abort got=%h exp=01", out_a); end
    bus_rd(3'd5, 1'b0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL pulse_reset_rd got=%h exp=0", rv); end
    @(negedge clk); reset = 1'b0;
    step();
  endtask

  task automatic test_edge_irq();
    bus_wr(3'd1, 32'h01, 1'b0);
    @(negedge clk); in_a = 8'h01;
    step(); step();
    bus_rd(3'd0, 1'b0, rv);
    total++; if (rv !== 32'h01) begin bad++; $display("FAIL in_sync got=%h exp=01", rv); end
    bus_rd(3'd2, 1'b0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL cap_early got=%h exp=0", rv); end
    step();
    bus_rd(3'd2, 1'b0, rv);
    total++; if (rv !== 32'h01) begin bad++; $display("FAIL cap_lat3 got=%h exp=01", rv); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq_a); end
    step();
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq_a); end
    bus_wr(3'd2, 32'h01, 1'b0);
    bus_rd(3'd2, 1'b0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL cap_clear got=%h exp=0", rv); end
    step();
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq_a); end
  endtask

  task automatic test_clear_vs_set();
    @(negedge clk); in_a = 8'h00;
    repeat (4) step();
    @(negedge clk); in_a = 8'h01;
    repeat (4) step();
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL cvs_pre_irq got=%b exp=1", irq_a); end
    @(negedge clk); in_a = 8'h00;
    repeat (4) step();
    @(negedge clk); in_a = 8'h01;
    step(); step();
    bus_wr(3'd2, 32'h01, 1'b0);
    bus_rd(3'd2, 1'b0, rv);
    total++; if (rv !== 32'h01) begin bad++; $display("FAIL set_wins got=%h exp=01", rv); end
    step();
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL set_wins_irq got=%b exp=1", irq_a); end

    bus_wr(3'd2, 32'h01, 1'b0);
    step();
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL nofall_pre got=%b exp=0", irq_a); end
    @(negedge clk); in_a = 8'h00;
    repeat (5) step();
    bus_rd(3'd2, 1'b0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL rising_ignores_fall got=%h exp=0", rv); end
  endtask

  task automatic test_any_edge();
    @(negedge clk); in_b = 8'h08;
    step(); step();
    @(negedge clk); in_b = 8'h00;
    step(); step();
    repeat (3) step();
    bus_rd(3'd2, 1'b1, rv);
    total++; if (rv !== 32'h08) begin bad++; $display("FAIL any_glitch got=%h exp=08", rv); end
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL any_masked got=%b exp=0", irq_b); end
    bus_wr(3'd1, 32'h08, 1'b1);
    step();
    total++; if (irq_b !== 1'b1) begin bad++; $display("FAIL any_unmask got=%b exp=1", irq_b); end

    @(negedge clk); in_b = 8'h08;
    repeat (5) step();
    bus_wr(3'd2, 32'h08, 1'b1);
    bus_rd(3'd2, 1'b1, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL any_clear got=%h exp=0", rv); end
    @(negedge clk); in_b = 8'h00;
    repeat (4) step();
    bus_rd(3'd2, 1'b1, rv);
    total++; if (rv !== 32'h08) begin bad++; $display("FAIL any_fall got=%h exp=08", rv); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; address = '0; cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1;
    writedata = '0; in_a = '0; in_b = '0;
    test_reset();
    test_setclr();
    test_pulse();
    test_edge_irq();
    test_clear_vs_set();
    test_any_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
